// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling 8-bit UART receiver feeding a show-ahead receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking; the default build is 8N1.
module uart_rx_fifo #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int fifo_depth = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx,
  input  logic                            rd_en,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  output logic [$clog2(fifo_depth+1)-1:0] fifo_count,
  output logic                            rx_done,
  output logic                            frame_err,
  output logic                            parity_err,
  output logic                            overrun
);

  localparam int div_raw = clk_freq / (baud_rate * 16);
  localparam int div     = (div_raw < 1) ? 1 : div_raw;
  localparam int div_w   = (div > 1) ? $clog2(div) : 1;
  localparam int ptr_w   = $clog2(fifo_depth);
  localparam int cnt_w   = $clog2(fifo_depth + 1);
  localparam logic [div_w-1:0] div_last = div_w'(div - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t state, state_nx;

  logic             rx_meta, rx_sync, rx_prev;
  logic [div_w-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic             tick, mid, bit_end;
  logic             samp7, samp8, vote;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             stop_dec, par_bad, good_byte;

  logic [7:0]       mem [fifo_depth];
  logic [ptr_w-1:0] wr_ptr, rd_ptr, rd_next;
  logic [cnt_w-1:0] count;
  logic             full, pop, push;

  // Synchronizer plus one-cycle history for falling-edge detection; all idle high.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Divider and tick counter are held at 0 in IDLE so each frame starts phase-aligned.
  assign tick    = (state != S_IDLE) && (div_cnt == div_last);
  assign mid     = tick && (tick_cnt == 4'd9);
  assign bit_end = tick && (tick_cnt == 4'd15);
  assign vote    = (samp7 & samp8) | (samp7 & rx_sync) | (samp8 & rx_sync);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      samp7    <= 1'b1;
      samp8    <= 1'b1;
    end else begin
      if (state == S_IDLE || tick) div_cnt <= '0;
      else                         div_cnt <= div_cnt + 1'b1;
      if (state == S_IDLE) tick_cnt <= '0;
      else if (tick)       tick_cnt <= tick_cnt + 1'b1;
      if (tick && tick_cnt == 4'd7) samp7 <= rx_sync;
      if (tick && tick_cnt == 4'd8) samp8 <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (rx_prev && !rx_sync) state_nx = S_START;
      S_START: begin
        if (mid && vote)  state_nx = S_IDLE;
        else if (bit_end) state_nx = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nx = S_PARITY;
`else
          state_nx = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (bit_end) state_nx = S_STOP;
`endif
      S_STOP:  if (mid) state_nx = vote ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_sync) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (state == S_IDLE)               bit_cnt <= '0;
      else if (state == S_DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
      if (state == S_DATA && mid) shift_reg <= {vote, shift_reg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         par_bit <= 1'b0;
    else if (state == S_PARITY && mid) par_bit <= vote;
  end

  // Even parity: data plus parity bit must hold an even number of ones.
  assign par_bad = ^{shift_reg, par_bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= stop_dec && par_bad;
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign stop_dec  = (state == S_STOP) && mid;
  assign good_byte = stop_dec && vote && !par_bad;

  // A simultaneous pop frees the slot, so a push into a full FIFO is accepted then.
  assign full     = (count == cnt_w'(fifo_depth));
  assign pop      = rd_en && (count != '0);
  assign push     = good_byte && (!full || pop);
  assign rd_next  = rd_ptr + 1'b1;
  assign rx_valid = (count != '0);
  assign fifo_count = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_done   <= push;
      frame_err <= stop_dec && !vote;
      overrun   <= good_byte && full && !pop;
    end
  end

  // NOTE: the storage array has no reset; rx_valid and count guard against reading stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  // rx_data is a registered copy of the head so it resets to 0 and holds once drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rx_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && (count == '0 || (pop && count == cnt_w'(1))))
        rx_data <= shift_reg;
      else if (pop && count > cnt_w'(1))
        rx_data <= mem[rd_next];
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames against a queue-based model of the receiver.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1536000;
  localparam int BAUD     = 9600;
  localparam int DEPTH    = 4;
  localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
  localparam int NB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PAR = 1'b0;
`endif
  // Stimulus step whose following edge is the stop-bit decision edge.
  localparam int DEC_I = 102 + BIT_CLKS * (NB - 1);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       rx_done, frame_err, parity_err, overrun;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .clk_freq(CLK_FREQ), .baud_rate(BAUD), .fifo_depth(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
    .rx_done(rx_done), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int c_done = 0, c_ferr = 0, c_perr = 0, c_ovr = 0;
  int e_done = 0, e_ferr = 0, e_perr = 0, e_ovr = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (rst) begin
      if (rx_done)    c_done++;
      if (frame_err)  c_ferr++;
      if (parity_err) c_perr++;
      if (overrun)    c_ovr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".done"},  c_done, e_done);
    check({tag, ".ferr"},  c_ferr, e_ferr);
    check({tag, ".perr"},  c_perr, e_perr);
    check({tag, ".ovr"},   c_ovr, e_ovr);
    check({tag, ".count"}, fifo_count, exp_q.size());
    check({tag, ".valid"}, rx_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check({tag, ".head"}, rx_data, exp_q[0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rx_data"}, rx_data, 0);
    check({tag, ".rx_valid"}, rx_valid, 0);
    check({tag, ".fifo_count"}, fifo_count, 0);
    check({tag, ".rx_done"}, rx_done, 0);
    check({tag, ".frame_err"}, frame_err, 0);
    check({tag, ".parity_err"}, parity_err, 0);
    check({tag, ".overrun"}, overrun, 0);
  endtask

  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d, input logic par, input logic stop);
    logic [NB-1:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[8:1] = d;
    if (PAR) b[9] = par;
    b[NB-1] = stop;
    return b;
  endfunction

  // Reference outcome of one frame: optional pop at the decision edge, then the frame's verdict.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop, input bit popped);
    bit par_ok;
    par_ok = !PAR || (((^d) ^ par) == 1'b0);
    if (popped && exp_q.size() > 0) void'(exp_q.pop_front());
    if (!stop) begin
      e_ferr++;
      if (!par_ok) e_perr++;
    end else if (!par_ok) begin
      e_perr++;
    end else if (exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
      e_done++;
    end else begin
      e_ovr++;
    end
  endtask

  // Drives one frame; a zero stop bit is followed by two more low bit times, then idle.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int pop_at);
    logic [NB-1:0] b;
    b = frame_bits(d, par, stop);
    for (int i = 0; i < NB * BIT_CLKS; i++) begin
      rx    = b[i / BIT_CLKS];
      rd_en = (i == pop_at);
      @(negedge clk);
    end
    rd_en = 1'b0;
    rx    = 1'b1;
    if (!stop) begin
      rx = 1'b0;
      repeat (2 * BIT_CLKS) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
    end
    model_frame(d, par, stop, pop_at == DEC_I);
  endtask

  task automatic good_frame(input logic [7:0] d);
    send_frame(d, ^d, 1'b1, -1);
  endtask

  task automatic pop_one(input string tag);
    check({tag, ".pop_valid"}, rx_valid, 1);
    check({tag, ".pop_data"}, rx_data, exp_q[0]);
    void'(exp_q.pop_front());
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0]    d;
    logic          par, stop;
    int            pop_at;
    logic [NB-1:0] b;

    // Reset state
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte
    good_frame(8'hA5);
    check_state("single");
    check("single.data", rx_data, 8'hA5);
    pop_one("single");
    check_state("single_popped");
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("empty_pop.count", fifo_count, 0);

    // Glitch shorter than the start-bit vote window
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check_state("glitch");

    // Framing error, then a clean frame after the line recovers
    send_frame(8'h3C, ^8'h3C, 1'b0, -1);
    check_state("frame_err");
    repeat (40) @(negedge clk);
    good_frame(8'h55);
    check_state("after_ferr");
    check("after_ferr.data", rx_data, 8'h55);
    pop_one("after_ferr");

    // Overrun on the fifth unread byte
    for (int k = 1; k <= 5; k++) good_frame(8'(k));
    check_state("overrun");
    check("overrun.pulses", c_ovr, 1);
    for (int k = 1; k <= 4; k++) begin
      check("overrun.order", rx_data, k);
      pop_one("overrun");
    end
    check_state("overrun_drained");

    // Push into a full FIFO with a pop on the same edge
    for (int k = 0; k < 4; k++) good_frame(8'h11 + 8'(k));
    check("full.count", fifo_count, 4);
    send_frame(8'h15, ^8'h15, 1'b1, DEC_I);
    check_state("push_pop_full");
    check("push_pop_full.count", fifo_count, 4);
    while (exp_q.size() > 0) pop_one("push_pop_full");

`ifdef UART_RX_PARITY_EN
    // Parity mismatch discards the byte; correct parity stores it
    send_frame(8'h01, 1'b0, 1'b1, -1);
    check_state("parity_bad");
    send_frame(8'h01, 1'b1, 1'b1, -1);
    check_state("parity_good");
    check("parity_good.data", rx_data, 8'h01);
    pop_one("parity_good");
`endif

    // Randomized frames with occasional framing/parity errors and reads
    for (int n = 0; n < 12; n++) begin
      d      = 8'($urandom);
      stop   = ($urandom_range(0, 4) != 0);
      par    = (^d) ^ ($urandom_range(0, 3) == 0);
      pop_at = ($urandom_range(0, 3) == 0) ? DEC_I : -1;
      send_frame(d, par, stop, pop_at);
      check_state("random");
      for (int p = $urandom_range(0, 2); p > 0; p--)
        if (exp_q.size() > 0) pop_one("random");
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    while (exp_q.size() > 0) pop_one("random_drain");

    // Reset during data bit 3 with a byte already buffered
    good_frame(8'h9E);
    check_state("pre_reset");
    b = frame_bits(8'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 700; i++) begin
      rx = b[i / BIT_CLKS];
      @(negedge clk);
    end
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b1;
    exp_q.delete();
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_state("post_reset");
    good_frame(8'h3C);
    check_state("post_reset_frame");
    check("post_reset_frame.data", rx_data, 8'h3C);
    pop_one("post_reset_frame");
    check_state("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
